vx_warp_barrier_unit: RTL and testbench
=======================================

// Module: vx_warp_barrier_unit
// PURPOSE
//  Per-core warp barrier controller; successor to the single-mask barrier handling in the warp scheduler.
//  Tracks NUM_BARRIERS independent local barriers, each with arrival count, waiting-warp mask and latched size.
//  Accepts one barrier_t-style arrival per cycle from the issue path.
//  Emits one registered release (warp mask) per completed barrier to the scheduler's unstall logic.
// PARAMETERS
//  NUM_WARPS     4  warps per core; NW_W = max(1, clog2(NUM_WARPS))
//  NUM_BARRIERS  4  independent barrier ids; NB_W = max(1, clog2(NUM_BARRIERS))
//  CTR_W         32 width of perf counters (BARRIER_PERF_EN only)
// PORTS
//  clk             in   1          clock
//  reset_n         in   1          reset
//  req_valid       in   1          arrival request valid
//  req_ready       out  1          unit can accept arrival
//  req_wid         in   NW_W       arriving warp id
//  req_id          in   NB_W       barrier id
//  req_size_m1     in   NW_W       participating warps minus one
//  req_is_noop     in   1          arrive without stalling (counted, not added to wait mask)
//  rel_valid       out  1          release pending
//  rel_ready       in   1          scheduler accepts release
//  rel_id          out  NB_W       released barrier id
//  rel_wmask       out  NUM_WARPS  warps to unstall
//  stalled_wmask   out  NUM_WARPS  OR of all barrier wait masks
//  err_dup         out  1          sticky: warp re-arrived at an open barrier
//  perf_waits      out  CTR_W      (BARRIER_PERF_EN) sum of stalled warps per cycle
//  perf_releases   out  CTR_W      (BARRIER_PERF_EN) releases handed off
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (reset_n=0 at clk edge): all counts=0, wait masks=0, arrived masks=0, open=0; rel_valid=0, rel_id=0,
//   rel_wmask=0, err_dup=0, perf counters=0; req_ready=1 after the reset edge.
//  Per barrier b: open[b], size_m1[b] (NW_W), count[b] (NW_W), arrived[b] (NUM_WARPS), wait[b] (NUM_WARPS).
//  States per barrier: IDLE (open=0) -> COLLECT (open=1) -> IDLE on completion.
//  Accept = req_valid & req_ready. req_ready = !rel_valid | rel_ready (release slot free or draining).
//  Arrival in IDLE: open=1, size_m1 latched from req; count=1, arrived={wid}; wait={wid} unless noop.
//  Arrival in COLLECT: size_m1 field ignored (first arrival wins); count+=1; arrived|=wid; wait|=wid unless noop.
//  Duplicate: arrived[b][wid] already set -> no state change, err_dup<=1 (sticky until reset).
//  Completion: accepted arrival where (pre-increment) count==size_m1[b], or size_m1==0 on IDLE arrival.
//   Same cycle: barrier b -> IDLE, count/arrived/wait cleared.
//   Next cycle: rel_valid=1, rel_id=b, rel_wmask=final wait mask (incl. arriving warp unless noop).
//  Release held stable while rel_valid & !rel_ready; cleared the cycle after handshake unless a new completion
//   loads it in the same cycle (back-to-back completions -> rel_valid stays 1, new id/mask).
//  stalled_wmask combinational from current wait masks; a completing warp is never visible as stalled.
//  Completion with all-noop arrivals: rel_valid still asserted, rel_wmask=0.
//  Latency: arrival -> rel_valid = 1 cycle; no bypass from req to rel outputs.
//  Count never wraps: completion at size_m1 (< NUM_WARPS) precedes overflow.
//  Reset mid-barrier: all partial arrivals discarded; pending release dropped.
// CONFIGURATION
//  BARRIER_PERF_EN defined: perf_waits += popcount(stalled_wmask) each cycle; perf_releases += 1 per rel
//   handshake; both wrap modulo 2^CTR_W.
//  BARRIER_PERF_EN undefined: perf_* ports absent, no counter logic.
// TESTING
//  T1 size_m1=3 id=2, warps 0..3 arrive one per cycle -> rel_valid 1 cycle after 4th, rel_id=2, rel_wmask=4'b1111.
//  T2 size_m1=0 id=0 wid=1 -> immediate completion, next cycle rel_wmask=4'b0010, stalled_wmask stays 0.
//  T3 warp 2 arrives twice at id=1 (size_m1=1) -> err_dup=1, count stays 1; warp 0 then completes, rel_wmask=4'b0101.
//  T4 rel_ready=0 for 5 cycles with completion pending -> req_ready=0, rel_id/rel_wmask stable; drain resumes.
//  T5 interleave id0 (size_m1=1) and id3 (size_m1=1), one noop arrival on id3 -> two releases, id3 wmask excludes noop warp.
//  T6 reset_n=0 after 2 of 4 arrivals -> all outputs zero, fresh size_m1 latched on next arrival; perf counters zero.

Source files
------------

// File: rtl/vx_warp_barrier_unit.sv
// Per-core warp barrier controller: NUM_BARRIERS independent barriers, one arrival per cycle,
// one registered release per completed barrier. Define BARRIER_PERF_EN to add perf counters.
module vx_warp_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
`ifdef BARRIER_PERF_EN
  parameter int CTR_W        = 32,
`endif
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_W-1:0]      req_wid,
  input  logic [NB_W-1:0]      req_id,
  input  logic [NW_W-1:0]      req_size_m1,
  input  logic                 req_is_noop,
  output logic                 rel_valid,
  input  logic                 rel_ready,
  output logic [NB_W-1:0]      rel_id,
  output logic [NUM_WARPS-1:0] rel_wmask,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  output logic                 err_dup
`ifdef BARRIER_PERF_EN
  ,
  output logic [CTR_W-1:0]     perf_waits,
  output logic [CTR_W-1:0]     perf_releases
`endif
);

  typedef enum logic {ST_IDLE, ST_COLLECT} bar_state_t;

  bar_state_t           state_q   [NUM_BARRIERS];
  logic [NW_W-1:0]      size_m1_q [NUM_BARRIERS];
  logic [NW_W-1:0]      count_q   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] arrived_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wait_q    [NUM_BARRIERS];

  logic                 accept;
  logic                 cur_open;
  logic                 dup;
  logic                 complete;
  logic [NUM_WARPS-1:0] wid_oh;
  logic [NUM_WARPS-1:0] add_mask;
  logic [NUM_WARPS-1:0] final_wait;

  assign req_ready = !rel_valid || rel_ready;
  assign accept    = req_valid && req_ready;
  assign cur_open  = (state_q[req_id] == ST_COLLECT);
  assign dup       = cur_open && arrived_q[req_id][req_wid];
  assign add_mask  = req_is_noop ? '0 : wid_oh;
  assign final_wait = (cur_open ? wait_q[req_id] : '0) | add_mask;

  // An IDLE arrival completes only a single-warp barrier; the first arrival's size is the one kept.
  assign complete = accept && !dup &&
                    (cur_open ? (count_q[req_id] == size_m1_q[req_id]) : (req_size_m1 == '0));

  always_comb begin
    wid_oh          = '0;
    wid_oh[req_wid] = 1'b1;
    stalled_wmask   = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) stalled_wmask |= wait_q[b];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b]   <= ST_IDLE;
        size_m1_q[b] <= '0;
        count_q[b]   <= '0;
        arrived_q[b] <= '0;
        wait_q[b]    <= '0;
      end
      rel_valid <= 1'b0;
      rel_id    <= '0;
      rel_wmask <= '0;
      err_dup   <= 1'b0;
    end else begin
      if (rel_valid && rel_ready) rel_valid <= 1'b0;
      if (accept) begin
        if (dup) begin
          err_dup <= 1'b1;
        end else if (complete) begin
          // A new completion reloads the slot even while the previous release is draining.
          state_q[req_id]   <= ST_IDLE;
          count_q[req_id]   <= '0;
          arrived_q[req_id] <= '0;
          wait_q[req_id]    <= '0;
          rel_valid         <= 1'b1;
          rel_id            <= req_id;
          rel_wmask         <= final_wait;
        end else if (!cur_open) begin
          state_q[req_id]   <= ST_COLLECT;
          size_m1_q[req_id] <= req_size_m1;
          count_q[req_id]   <= NW_W'(1);
          arrived_q[req_id] <= wid_oh;
          wait_q[req_id]    <= add_mask;
        end else begin
          count_q[req_id]   <= count_q[req_id] + NW_W'(1);
          arrived_q[req_id] <= arrived_q[req_id] | wid_oh;
          wait_q[req_id]    <= final_wait;
        end
      end
    end
  end

`ifdef BARRIER_PERF_EN
  function automatic logic [CTR_W-1:0] popcount(input logic [NUM_WARPS-1:0] m);
    logic [CTR_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_WARPS; i++) n = n + CTR_W'(m[i]);
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_waits    <= '0;
      perf_releases <= '0;
    end else begin
      perf_waits <= perf_waits + popcount(stalled_wmask);
      if (rel_valid && rel_ready) perf_releases <= perf_releases + CTR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vx_warp_barrier_unit.sv
// Scoreboard bench for vx_warp_barrier_unit: expected releases queued at arrival, checked on handshake.
module tb_vx_warp_barrier_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_wid = '0;
  logic [1:0] req_id = '0;
  logic [1:0] req_size_m1 = '0;
  logic       req_is_noop = 1'b0;
  logic       rel_valid;
  logic       rel_ready = 1'b1;
  logic [1:0] rel_id;
  logic [3:0] rel_wmask;
  logic [3:0] stalled_wmask;
  logic       err_dup;
`ifdef BARRIER_PERF_EN
  logic [31:0] perf_waits;
  logic [31:0] perf_releases;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] id;
    logic [3:0] mask;
  } rel_t;
  rel_t exp_q[$];

  vx_warp_barrier_unit dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_id(req_id),
    .req_size_m1(req_size_m1), .req_is_noop(req_is_noop),
    .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_id(rel_id), .rel_wmask(rel_wmask),
    .stalled_wmask(stalled_wmask), .err_dup(err_dup)
`ifdef BARRIER_PERF_EN
    , .perf_waits(perf_waits), .perf_releases(perf_releases)
`endif
  );

  always #5 clk = ~clk;

  // Release monitor: every observed handshake must match the oldest expected release.
  always @(negedge clk) begin
    rel_t r;
    if (reset_n && rel_valid && rel_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_release: got id=%0d mask=%b, required none", rel_id, rel_wmask);
      end else begin
        r = exp_q.pop_front();
        if (rel_id !== r.id || rel_wmask !== r.mask) begin
          n_fail++;
          $display("FAIL release: got id=%0d mask=%b, required id=%0d mask=%b",
                   rel_id, rel_wmask, r.id, r.mask);
        end
      end
    end
  end

  task automatic arrive(input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sm1,
                        input logic noop, input logic done, input logic [3:0] mask);
    rel_t e;
    req_wid = wid; req_id = id; req_size_m1 = sm1; req_is_noop = noop; req_valid = 1'b1;
    if (done) begin
      e.id = id; e.mask = mask;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d releases outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (rel_valid !== 1'b0 || rel_id !== 2'd0 || rel_wmask !== 4'd0 ||
        stalled_wmask !== 4'd0 || err_dup !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got rv=%b id=%0d wm=%b st=%b dup=%b rdy=%b, required 0 0 0000 0000 0 1",
               name, rel_valid, rel_id, rel_wmask, stalled_wmask, err_dup, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_full_barrier();
    arrive(2'd0, 2'd2, 2'd3, 1'b0, 1'b0, 4'b0);
    arrive(2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'b0);
    arrive(2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 4'b0);
    n_checks++;
    if (stalled_wmask !== 4'b0111 || rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_partial: got st=%b rv=%b, required 0111 0", stalled_wmask, rel_valid);
    end
    arrive(2'd3, 2'd2, 2'd0, 1'b0, 1'b1, 4'b1111);
    n_checks++;
    if (rel_valid !== 1'b1 || stalled_wmask !== 4'b0000) begin
      n_fail++;
      $display("FAIL t1_latency: got rv=%b st=%b, required 1 0000", rel_valid, stalled_wmask);
    end
    wait_drain("t1");
  endtask

  task automatic test_single_warp();
    arrive(2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'b0010);
    n_checks++;
    if (stalled_wmask !== 4'b0000 || rel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_immediate: got st=%b rv=%b, required 0000 1", stalled_wmask, rel_valid);
    end
    wait_drain("t2");
  endtask

  task automatic test_duplicate();
    arrive(2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'b0);
    n_checks++;
    if (err_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_no_dup_yet: got err_dup=%b, required 0", err_dup);
    end
    arrive(2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'b0);
    n_checks++;
    if (err_dup !== 1'b1 || stalled_wmask !== 4'b0100 || rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_dup: got dup=%b st=%b rv=%b, required 1 0100 0", err_dup, stalled_wmask, rel_valid);
    end
    arrive(2'd0, 2'd1, 2'd3, 1'b0, 1'b1, 4'b0101);
    wait_drain("t3");
    n_checks++;
    if (err_dup !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_sticky: got err_dup=%b, required 1", err_dup);
    end
  endtask

  task automatic test_backpressure();
    rel_t e;
    rel_ready = 1'b0;
    arrive(2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 4'b1000);
    // Hold a second single-warp completion while the release slot is blocked.
    req_wid = 2'd0; req_id = 2'd0; req_size_m1 = 2'd0; req_is_noop = 1'b0; req_valid = 1'b1;
    e.id = 2'd0; e.mask = 4'b0001;
    exp_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_ready !== 1'b0 || rel_valid !== 1'b1 || rel_id !== 2'd3 || rel_wmask !== 4'b1000) begin
        n_fail++;
        $display("FAIL t4_hold[%0d]: got rdy=%b rv=%b id=%0d wm=%b, required 0 1 3 1000",
                 i, req_ready, rel_valid, rel_id, rel_wmask);
      end
      @(posedge clk); #1;
    end
    rel_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (rel_valid !== 1'b1 || rel_id !== 2'd0 || rel_wmask !== 4'b0001) begin
      n_fail++;
      $display("FAIL t4_back_to_back: got rv=%b id=%0d wm=%b, required 1 0 0001", rel_valid, rel_id, rel_wmask);
    end
    wait_drain("t4");
    @(posedge clk); #1;
    n_checks++;
    if (rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_cleared: got rv=%b, required 0", rel_valid);
    end
  endtask

  task automatic test_interleave_noop();
    arrive(2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0);
    arrive(2'd1, 2'd3, 2'd1, 1'b1, 1'b0, 4'b0);
    n_checks++;
    if (stalled_wmask !== 4'b0001) begin
      n_fail++;
      $display("FAIL t5_stalled: got %b, required 0001", stalled_wmask);
    end
    arrive(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'b0101);
    arrive(2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 4'b1000);
    arrive(2'd1, 2'd2, 2'd0, 1'b1, 1'b1, 4'b0000);
    wait_drain("t5");
  endtask

  task automatic test_reset_mid_barrier();
    arrive(2'd0, 2'd2, 2'd3, 1'b0, 1'b0, 4'b0);
    arrive(2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_idle_outputs("t6_after_reset");
`ifdef BARRIER_PERF_EN
    n_checks++;
    if (perf_waits !== 32'd0 || perf_releases !== 32'd0) begin
      n_fail++;
      $display("FAIL t6_perf: got waits=%0d rels=%0d, required 0 0", perf_waits, perf_releases);
    end
`endif
    arrive(2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 4'b0);
    arrive(2'd3, 2'd2, 2'd3, 1'b0, 1'b1, 4'b1100);
    wait_drain("t6");
  endtask

  initial begin
    test_reset();
    test_full_barrier();
    test_single_warp();
    test_duplicate();
    test_backpressure();
    test_interleave_noop();
    test_reset_mid_barrier();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
